ft245_sync_to_axis_bridge: RTL and testbench

//  Bridges an FTDI FT245-style synchronous FIFO port to a pair of AXI-Stream interfaces.
//  - Host->FPGA bytes read from the chip leave on m_axis.
//  - s_axis words are written to the chip.
//  - Sits at the board edge and runs entirely in the chip-supplied 60 MHz clock domain.

---
 rtl/ft245_sync_pkg.sv | 21 ++
 rtl/ft245_rx_skid_fifo.sv | 44 ++++
 rtl/ft245_sync_to_axis_bridge.sv | 112 +++++++++++
 tb/tb_ft245_sync_to_axis_bridge.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ft245_sync_pkg.sv
// Shared types and sizing for the FT245 synchronous FIFO to AXI-Stream bridge.
package ft245_sync_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RD_OE = 2'd1,
    READ  = 2'd2,
    WRITE = 2'd3
  } state_t;

  typedef enum logic {
    PRIO_RX = 1'b0,
    PRIO_TX = 1'b1
  } prio_t;

  localparam int unsigned RX_FIFO_DEPTH  = 4;
  localparam int unsigned RX_FIFO_MARGIN = 2;
  localparam int unsigned RX_PTR_W       = $clog2(RX_FIFO_DEPTH);
  localparam int unsigned RX_CNT_W       = $clog2(RX_FIFO_DEPTH + 1);

endpackage

// File: rtl/ft245_rx_skid_fifo.sv
// Small receive FIFO between the FT read strobe and m_axis; reports free entries.
module ft245_rx_skid_fifo
  import ft245_sync_pkg::*;
#(
  parameter int unsigned DW = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                push,
  input  logic [DW-1:0]       push_data,
  output logic [DW-1:0]       m_axis_tdata,
  output logic                m_axis_tvalid,
  input  logic                m_axis_tready,
  output logic [RX_CNT_W-1:0] fifo_free
);

  logic [DW-1:0]       mem [RX_FIFO_DEPTH];
  logic [RX_PTR_W-1:0] wr_ptr;
  logic [RX_PTR_W-1:0] rd_ptr;
  logic [RX_CNT_W-1:0] count;
  logic                pop;

  assign pop           = m_axis_tvalid && m_axis_tready;
  assign m_axis_tvalid = (count != '0);
  assign m_axis_tdata  = mem[rd_ptr];
  assign fifo_free     = RX_CNT_W'(RX_FIFO_DEPTH) - count;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + RX_PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + RX_PTR_W'(1);
      count <= count + RX_CNT_W'(push) - RX_CNT_W'(pop);
    end
  end

endmodule

// File: rtl/ft245_sync_to_axis_bridge.sv
// FT245 synchronous FIFO port to m_axis (host->FPGA) and s_axis (FPGA->host).
// Define FT245_SIWU_EN to add the ft245_siwu_n send-immediate output.
module ft245_sync_to_axis_bridge
  import ft245_sync_pkg::*;
#(
  parameter int unsigned bus_width = 1,
  localparam int unsigned DW = 8 * bus_width
) (
  input  logic          ft245_clk,
  input  logic          rstn,
  inout  wire  [DW-1:0] ft245_data,
  input  logic          ft245_rxf_n,
  input  logic          ft245_txe_n,
  output logic          ft245_rd_n,
  output logic          ft245_wr_n,
  output logic          ft245_oe_n,
`ifdef FT245_SIWU_EN
  output logic          ft245_siwu_n,
`endif
  output logic [DW-1:0] m_axis_tdata,
  output logic          m_axis_tvalid,
  input  logic          m_axis_tready,
  input  logic [DW-1:0] s_axis_tdata,
  input  logic          s_axis_tvalid,
  output logic          s_axis_tready
);

  state_t              state;
  prio_t               prio;
  logic                rd_n_q;
  logic                oe_n_q;
  logic                drive_q;
  logic                rx_push;
  logic                rx_req;
  logic                tx_req;
  logic                rd_exit;
  logic                wr_exit;
  logic [RX_CNT_W-1:0] fifo_free;

  assign rx_req  = !ft245_rxf_n && (fifo_free >= RX_CNT_W'(RX_FIFO_MARGIN + 1));
  assign tx_req  = !ft245_txe_n && s_axis_tvalid;
  assign rd_exit = ft245_rxf_n || (fifo_free <= RX_CNT_W'(RX_FIFO_MARGIN));
  assign wr_exit = ft245_txe_n || !s_axis_tvalid;
  assign rx_push = !rd_n_q && !ft245_rxf_n;

  assign ft245_rd_n    = rd_n_q;
  assign ft245_oe_n    = oe_n_q;
  assign s_axis_tready = (state == WRITE) && !ft245_txe_n;
  assign ft245_wr_n    = !((state == WRITE) && s_axis_tvalid && !ft245_txe_n);

  // Keep driving for one cycle after WRITE; the mandatory IDLE gap covers it.
  assign ft245_data = ((state == WRITE) || drive_q) ? s_axis_tdata : {DW{1'bz}};

  always_ff @(posedge ft245_clk or negedge rstn) begin
    if (!rstn) begin
      state   <= IDLE;
      prio    <= PRIO_RX;
      rd_n_q  <= 1'b1;
      oe_n_q  <= 1'b1;
      drive_q <= 1'b0;
`ifdef FT245_SIWU_EN
      ft245_siwu_n <= 1'b1;
`endif
    end else begin
      drive_q <= (state == WRITE);
`ifdef FT245_SIWU_EN
      ft245_siwu_n <= !((state == WRITE) && !s_axis_tvalid);
`endif
      case (state)
        IDLE: begin
          if (rx_req && (!tx_req || (prio == PRIO_RX))) begin
            state  <= RD_OE;
            oe_n_q <= 1'b0;
          end else if (tx_req) begin
            state <= WRITE;
          end
        end
        RD_OE: begin
          state  <= READ;
          rd_n_q <= 1'b0;
        end
        READ: begin
          if (rd_exit) begin
            state  <= IDLE;
            rd_n_q <= 1'b1;
            oe_n_q <= 1'b1;
            prio   <= PRIO_TX;
          end
        end
        WRITE: begin
          if (wr_exit) begin
            state <= IDLE;
            prio  <= PRIO_RX;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  ft245_rx_skid_fifo #(.DW(DW)) u_rx_fifo (
    .clk           (ft245_clk),
    .rst_n         (rstn),
    .push          (rx_push),
    .push_data     (ft245_data),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .fifo_free     (fifo_free)
  );

endmodule

// File: tb/tb_ft245_sync_to_axis_bridge.sv
// Scoreboard bench for ft245_sync_to_axis_bridge with a behavioural FT245 chip model.
module tb_ft245_sync_to_axis_bridge;

  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  wire  [DW-1:0] ft_bus;
  logic          rxf_n = 1'b1;
  logic          txe_n = 1'b0;
  logic          rd_n, wr_n, oe_n;
  logic [DW-1:0] m_tdata;
  logic          m_tvalid;
  logic          m_tready = 1'b1;
  logic [DW-1:0] s_tdata = '0;
  logic          s_tvalid = 1'b0;
  logic          s_tready;
  logic [DW-1:0] chip_drv = '0;
`ifdef FT245_SIWU_EN
  logic          siwu_n;
`endif

  always #8 clk = ~clk;

  pullup (ft_bus);
  assign ft_bus = (!oe_n) ? chip_drv : {DW{1'bz}};

  ft245_sync_to_axis_bridge #(.bus_width(1)) dut (
    .ft245_clk     (clk),
    .rstn          (rstn),
    .ft245_data    (ft_bus),
    .ft245_rxf_n   (rxf_n),
    .ft245_txe_n   (txe_n),
    .ft245_rd_n    (rd_n),
    .ft245_wr_n    (wr_n),
    .ft245_oe_n    (oe_n),
`ifdef FT245_SIWU_EN
    .ft245_siwu_n  (siwu_n),
`endif
    .m_axis_tdata  (m_tdata),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tready (m_tready),
    .s_axis_tdata  (s_tdata),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tready (s_tready)
  );

  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0] exp_rx[$];
  logic [7:0] exp_tx[$];

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, req, $time);
    end
  endfunction

  // Chip model state: rx bytes waiting in the chip, tx words offered on s_axis
  logic [7:0] rx_mem [0:63];
  logic [7:0] src_mem [0:63];
  int rx_wr = 0, rx_rd = 0, src_cnt = 0, src_idx = 0, tx_got = 0;
  int rx_pause = 0, tx_pause = 0;
  bit bursty = 1'b0;
  bit tx_hold = 1'b0;

  initial begin
    bit rx_ev, tx_ev, s_ev;
    forever begin
      @(negedge clk);
      rx_ev = !rd_n && !rxf_n;
      tx_ev = !wr_n;
      s_ev  = s_tvalid && s_tready;
      @(posedge clk);
      #1;
      if (rx_pause != 0) rx_pause--;
      if (tx_pause != 0) tx_pause--;
      if (rx_ev) begin
        rx_rd++;
        if (bursty && (rx_rd % 4 == 0)) rx_pause = 2;
      end
      if (tx_ev) begin
        tx_got++;
        if (bursty && (tx_got % 4 == 0)) tx_pause = 2;
      end
      if (s_ev) src_idx++;
      rxf_n    = (rx_rd >= rx_wr) || (rx_pause != 0);
      txe_n    = tx_hold || (tx_pause != 0);
      s_tvalid = (src_idx < src_cnt);
      s_tdata  = src_mem[src_idx % 64];
      chip_drv = rx_mem[rx_rd % 64];
    end
  end

  // Monitor: scoreboard pops plus bus-protocol checks, sampled mid-cycle
  int  occ = 0;
  int  switches = 0;
  int  last_kind = 0;
  logic prev_wr_n = 1'b1, prev_oe_n = 1'b1, prev_rd_n = 1'b1;
  logic prev_mv = 1'b0, prev_mr = 1'b0;
  logic [7:0] prev_md = '0;

  initial begin
    bit push, pop;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        occ = 0;
        prev_wr_n = 1'b1; prev_oe_n = 1'b1; prev_rd_n = 1'b1;
        prev_mv = 1'b0; prev_mr = 1'b0;
      end else begin
        push = !rd_n && !rxf_n;
        pop  = m_tvalid && m_tready;
        if (pop) begin
          chk("rx_expected_avail", 32'(exp_rx.size() != 0), 1);
          if (exp_rx.size() != 0) chk("m_axis_tdata", m_tdata, exp_rx.pop_front());
        end
        if (!wr_n) begin
          chk("tx_expected_avail", 32'(exp_tx.size() != 0), 1);
          if (exp_tx.size() != 0) chk("tx_bus_word", ft_bus, exp_tx.pop_front());
        end
        if (prev_mv && !prev_mr) chk("m_axis_hold", m_tdata, prev_md);
        if (!oe_n) begin
          chk("rx_bus_owner", ft_bus, chip_drv);
          chk("turnaround_gap", prev_wr_n, 1);
        end
        if (!oe_n && prev_oe_n) chk("oe_before_rd", rd_n, 1);
        if (!rd_n && prev_rd_n) chk("rd_after_oe", prev_oe_n, 0);
        if (txe_n) begin
          chk("tready_vs_txe", s_tready, 0);
          chk("wr_n_vs_txe", wr_n, 1);
        end
        if (push) chk("rx_fifo_room", 32'((occ + 1 - int'(pop)) <= 4), 1);
        occ = occ + int'(push) - int'(pop);
        if (!rd_n) begin
          if (last_kind == 2) switches++;
          last_kind = 1;
        end
        if (!wr_n) begin
          if (last_kind == 1) switches++;
          last_kind = 2;
        end
        prev_wr_n = wr_n; prev_oe_n = oe_n; prev_rd_n = rd_n;
        prev_mv = m_tvalid; prev_mr = m_tready; prev_md = m_tdata;
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic load_rx(input int n, input logic [7:0] base, input bit expect_it);
    for (int i = 0; i < n; i++) begin
      rx_mem[(rx_wr + i) % 64] = base + 8'(i);
      if (expect_it) exp_rx.push_back(base + 8'(i));
    end
    rx_wr += n;
  endtask

  task automatic load_tx(input int n);
    for (int i = 0; i < n; i++) begin
      src_mem[(src_cnt + i) % 64] = 8'(65 + src_cnt + i);
      exp_tx.push_back(8'(65 + src_cnt + i));
    end
    src_cnt += n;
  endtask

  task automatic wait_empty(input string nm, input int budget);
    int n = 0;
    while ((exp_rx.size() != 0 || exp_tx.size() != 0) && n < budget) begin
      step(1);
      n++;
    end
    chk(nm, 32'(exp_rx.size() + exp_tx.size()), 0);
  endtask

  initial begin
    int n;
    // Reset with a pending tx source: nothing may move
    load_tx(6);
    #250;
    @(negedge clk);
    chk("rst_rd_n", rd_n, 1);
    chk("rst_wr_n", wr_n, 1);
    chk("rst_oe_n", oe_n, 1);
    chk("rst_bus_released", ft_bus, 8'hFF);
    chk("rst_m_tvalid", m_tvalid, 0);
    chk("rst_s_tready", s_tready, 0);
`ifdef FT245_SIWU_EN
    chk("rst_siwu_n", siwu_n, 1);
`endif
    #244;
    rstn = 1'b1;

    // Back-to-back write burst 65..70
    wait_empty("tx_burst_drained", 100);

    // Chip full mid-burst: stall then resume on the same word
    load_tx(6);
    step(4);
    tx_hold = 1'b1;
    step(3);
    tx_hold = 1'b0;
    wait_empty("tx_stall_drained", 100);

    // Ten-byte read with a free-running sink
    m_tready = 1'b1;
    load_rx(10, 8'h10, 1'b1);
    wait_empty("rx_burst_drained", 200);

    // Ten-byte read with a stalled sink: reads must stop at the margin
    m_tready = 1'b0;
    load_rx(10, 8'h20, 1'b1);
    step(20);
    chk("rx_stall_rd_n", rd_n, 1);
    chk("rx_stall_oe_n", oe_n, 1);
    chk("rx_stall_tvalid", m_tvalid, 1);
    chk("rx_stall_fill", 32'(occ >= 2 && occ <= 4), 1);
    m_tready = 1'b1;
    wait_empty("rx_stall_drained", 300);

    // Both directions bursty: must alternate with idle gaps
    bursty = 1'b1;
    switches = 0;
    load_rx(12, 8'h30, 1'b1);
    load_tx(8);
    wait_empty("mixed_drained", 400);
    chk("rx_tx_alternation", 32'(switches >= 3), 1);
    bursty = 1'b0;
    step(4);

    // Reset mid-write with bytes sitting in the rx FIFO
    m_tready = 1'b0;
    load_rx(3, 8'h50, 1'b0);
    n = 0;
    while (!(m_tvalid && rd_n && rx_rd == rx_wr) && n < 100) begin step(1); n++; end
    chk("rx_prefill", m_tvalid, 1);
    load_tx(20);
    n = 0;
    while (wr_n && n < 100) begin step(1); n++; end
    chk("tx_started", wr_n, 0);
    @(posedge clk);
    #3;
    rstn = 1'b0;
    src_cnt = src_idx;
    exp_tx.delete();
    #1;
    chk("midrst_wr_n", wr_n, 1);
    chk("midrst_rd_n", rd_n, 1);
    chk("midrst_oe_n", oe_n, 1);
    chk("midrst_s_tready", s_tready, 0);
    chk("midrst_fifo_cleared", m_tvalid, 0);
    step(4);
    rstn = 1'b1;
    step(3);
    #6;
    chk("post_rst_tvalid", m_tvalid, 0);
    chk("post_rst_wr_n", wr_n, 1);
    chk("post_rst_bus", ft_bus, 8'hFF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, tests run %0d", n_tests);
    $fatal(1);
  end

endmodule
